vsync_gen: RTL and testbench
============================

# vsync_gen

Vertical timing stage of the display pipeline, directly downstream of the vertical line counter. It samples the counter's current line number at each end-of-line strobe and decodes the vertical state machine. It produces the registered vertical sync and blanking levels, plus the frame-start strobe. It issues the clear pulse that wraps the vertical counter at end of frame, and tracks its own expected line to flag counter desynchronisation.

## Interface
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, front-porch lines
- V_SYNC, 2, sync-pulse lines
- V_BP, 33, back-porch lines
- VSYNC_POL, 0, sync active level (0 = active-low)
- clk  in  1  pixel clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- line_end  in  1  one-cycle strobe on the last pixel of every line
- v_count  in  10  current line from the vertical counter, valid when line_end = 1
- v_clr  out  1  one-cycle pulse; drives the vertical counter's clear input
- vsync  out  1  vertical sync at VSYNC_POL polarity
- v_blank  out  1  high outside the visible region
- frame_start  out  1  one-cycle pulse when line 0 begins
- frame_count  out  16  frames started since reset
- sync_err  out  1  sticky flag: v_count disagreed with the expected line or was out of range

## Operation
- TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default); it must be ≤ 1024. All comparisons are unsigned, 10 bits.
- States: ACTIVE, FPORCH, SYNC, BPORCH. The state changes only in the cycle after line_end = 1.
- exp_line: internal 10-bit expected line number; reset value 0.
- On line_end:
  - Check: if v_count ≠ exp_line, or v_count ≥ TOTAL, set sync_err. Resynchronise by treating v_count as the current line.
  - Next line: n = current+1. If current ≥ TOTAL-1, then n = 0 and v_clr pulses.
  - Update: exp_line ← n. The state is decoded from n:
    - ACTIVE if n < V_ACTIVE
    - FPORCH if n < V_ACTIVE+V_FP
    - SYNC if n < V_ACTIVE+V_FP+V_SYNC
    - BPORCH otherwise
- vsync = VSYNC_POL in SYNC, ~VSYNC_POL in every other state. v_blank = 1 in any state except ACTIVE.
- frame_start pulses whenever n = 0, including on an out-of-range wrap.
- frame_count increments on each frame_start; it wraps modulo 2^16.
- sync_err is cleared only by rst.
- No line_end: all outputs hold, and the pulse outputs are 0.

## Timing
- Every output is a flop; none depends combinationally on the inputs.
- Latency: line_end sampled at edge k → vsync, v_blank, v_clr, frame_start and frame_count updated at edge k+1.
- v_clr is high exactly one clk. The counter clears asynchronously, so by the next line_end v_count reads 0.
- Back-to-back line_end on consecutive clocks is legal; each strobe is processed independently.
- Reset values:
  - state ACTIVE, exp_line 0
  - vsync = ~VSYNC_POL, v_blank 0
  - v_clr 0, frame_start 0
  - frame_count 0, sync_err 0
- rst asserted mid-frame: everything returns to its reset value immediately. The vertical counter is reset by the shared global reset at the same time, so the first post-reset line_end sees v_count 0 with no error.

## Configuration
- VSYNC_FRAME_COUNT_EN defined: the 16-bit frame counter is built and frame_count behaves as described above.
- VSYNC_FRAME_COUNT_EN undefined: no counter flops are built and frame_count is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then 525 line_end strobes with v_count following 0..524 → sync_err stays 0 and:
  - v_blank rises after line 479's strobe
  - vsync low for exactly lines 490–491
  - v_clr and frame_start pulse once, the cycle after line 524's strobe
  - frame_count = 1
- Three full frames → frame_count = 3 with the macro defined, 0 without it. vsync behaves identically in both builds.
- v_count = 100 when exp_line = 99 → sync_err = 1 and exp_line resyncs to 101. Subsequent lines track without further error, and sync_err remains 1.
- v_count = 600 (out of range) → sync_err = 1, v_clr pulses, frame_start pulses, and the state is ACTIVE with v_blank 0.
- rst asserted while in SYNC → vsync = 1 and v_blank = 0 immediately, without waiting for clk. With default VSYNC_POL this is the inactive level; frame_count = 0 and sync_err = 0.
- line_end on two consecutive clocks at lines 488, 489 → state FPORCH then SYNC on consecutive edges, with vsync falling one clk after the second strobe.

Source files
------------

// File: rtl/vsync_gen.sv
// vsync_gen: vertical timing stage downstream of the vertical line counter.
// Samples v_count on each line_end strobe, then on the following edge advances
// the vertical FSM and updates the registered vsync / v_blank levels, the
// v_clr / frame_start pulses and the sticky sync_err flag.
// Optional feature: define VSYNC_FRAME_COUNT_EN to build the 16-bit frame
// counter; otherwise frame_count is tied to 0.
module vsync_gen #(
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter logic        VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_end,
    input  logic [9:0]  v_count,
    output logic        v_clr,
    output logic        vsync,
    output logic        v_blank,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic        sync_err
);

    localparam int unsigned LINE_W = 10;
    localparam int unsigned CMP_W  = LINE_W + 1;
    localparam int unsigned TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // One extra bit so a 1024-line frame still compares correctly.
    localparam logic [CMP_W-1:0] ACT_END = CMP_W'(V_ACTIVE);
    localparam logic [CMP_W-1:0] FP_END  = CMP_W'(V_ACTIVE + V_FP);
    localparam logic [CMP_W-1:0] SY_END  = CMP_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CMP_W-1:0] TOT_CMP = CMP_W'(TOTAL);
    localparam logic [CMP_W-1:0] LAST    = CMP_W'(TOTAL - 1);

    typedef enum logic [1:0] {ACTIVE, FPORCH, SYNC, BPORCH} state_t;

    state_t              state;
    state_t              next_state;
    logic [LINE_W-1:0]   exp_line;
    logic                le_q;
    logic [LINE_W-1:0]   vc_q;
    logic [CMP_W-1:0]    cur;
    logic [CMP_W-1:0]    nxt;
    logic                mismatch;
    logic                wrap;

    // Capture the counter value at the end-of-line strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            le_q <= 1'b0;
            vc_q <= '0;
        end else begin
            le_q <= line_end;
            vc_q <= v_count;
        end
    end

    // Check sampled line, compute next line and decode the next state.
    always_comb begin
        cur        = {1'b0, vc_q};
        mismatch   = (vc_q != exp_line) || (cur >= TOT_CMP);
        wrap       = (cur >= LAST);
        nxt        = wrap ? '0 : cur + CMP_W'(1);
        next_state = state;
        if (le_q) begin
            if (nxt < ACT_END)     next_state = ACTIVE;
            else if (nxt < FP_END) next_state = FPORCH;
            else if (nxt < SY_END) next_state = SYNC;
            else                   next_state = BPORCH;
        end
    end

    // Vertical FSM with registered level and pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ACTIVE;
            exp_line    <= '0;
            vsync       <= ~VSYNC_POL;
            v_blank     <= 1'b0;
            v_clr       <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= next_state;
            vsync       <= (next_state == SYNC) ? VSYNC_POL : ~VSYNC_POL;
            v_blank     <= (next_state != ACTIVE);
            v_clr       <= le_q && wrap;
            frame_start <= le_q && wrap;
            if (le_q) begin
                exp_line <= nxt[LINE_W-1:0];
                if (mismatch) sync_err <= 1'b1;
            end
        end
    end

`ifdef VSYNC_FRAME_COUNT_EN
    // Count frame starts, wrapping modulo 2^16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              frame_count <= '0;
        else if (le_q && wrap) frame_count <= frame_count + 16'd1;
    end
`else
    assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_vsync_gen.sv
// Bench for vsync_gen: stimulus pushes expected outputs per cycle into a queue,
// a monitor on the falling edge pops and compares them.
module tb_vsync_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_end;
    logic [9:0]  v_count;
    logic        v_clr;
    logic        vsync;
    logic        v_blank;
    logic        frame_start;
    logic [15:0] frame_count;
    logic        sync_err;

    vsync_gen dut (
        .clk         (clk),
        .rst         (rst),
        .line_end    (line_end),
        .v_count     (v_count),
        .v_clr       (v_clr),
        .vsync       (vsync),
        .v_blank     (v_blank),
        .frame_start (frame_start),
        .frame_count (frame_count),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] vec;   // {v_clr, vsync, v_blank, frame_start, frame_count, sync_err}
        int          due;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    // Reference of the vertical timing for the default 480/10/2/33 frame.
    int          m_exp;
    logic        m_vsync, m_blank, m_err;
    logic [15:0] m_fc;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [20:0] pack(input logic clr, input logic fs);
        return {clr, m_vsync, m_blank, fs, m_fc, m_err};
    endfunction

    task automatic model_reset();
        m_exp = 0; m_vsync = 1'b1; m_blank = 1'b0; m_err = 1'b0; m_fc = 16'd0;
    endtask

    // One clock of stimulus; le=1 issues a strobe with line vc.
    task automatic step(input logic le, input int vc, input string tag);
        exp_t e;
        logic clr;
        int   n;
        @(posedge clk); #1;
        line_end = le;
        v_count  = 10'(vc);
        clr = 1'b0;
        if (le) begin
            if (vc != m_exp || vc >= 525) m_err = 1'b1;
            if (vc >= 524) begin n = 0; clr = 1'b1; end
            else n = vc + 1;
            m_exp   = n;
            m_blank = (n >= 480);
            m_vsync = !(n >= 490 && n < 492);
`ifdef VSYNC_FRAME_COUNT_EN
            if (clr) m_fc = m_fc + 16'd1;
`endif
        end
        e.vec = pack(clr, clr);
        e.due = cyc + 2;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic line(input int vc, input string tag);
        step(1'b1, vc, tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 0, tag);
    endtask

    task automatic drain();
        idle("drain"); idle("drain");
        repeat (3) @(posedge clk);
        #1 line_end = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare every due expectation on the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            logic [20:0] act;
            e = q.pop_front();
            act = {v_clr, vsync, v_blank, frame_start, frame_count, sync_err};
            tests++;
            if (e.due != cyc) begin
                fails++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.tag, e.due, cyc);
            end else if (act !== e.vec) begin
                fails++;
                $display("FAIL %s @cyc %0d: got clr/vs/vb/fs/fc/err=%0h, expected %0h",
                         e.tag, cyc, act, e.vec);
            end
        end
    end

    logic [15:0] fc_req;

    initial begin
        rst = 1'b1; line_end = 1'b0; v_count = 10'd0;
        model_reset();
        #12;
        check("reset_vsync", 32'(vsync), 32'd1);
        check("reset_vblank", 32'(v_blank), 32'd0);
        check("reset_pulses", 32'({v_clr, frame_start}), 32'd0);
        check("reset_fc_err", 32'({frame_count, sync_err}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) idle("post_reset_idle");

        // Frame 1: strobes separated by idle clocks.
        for (int i = 0; i < 525; i++) begin
            line(i, "frame1");
            idle("frame1_gap");
        end
        drain();
`ifdef VSYNC_FRAME_COUNT_EN
        fc_req = 16'd1;
`else
        fc_req = 16'd0;
`endif
        check("frame1_count", 32'(frame_count), 32'(fc_req));
        check("frame1_no_err", 32'(sync_err), 32'd0);

        // Frames 2 and 3 with back-to-back strobes (includes 488,489).
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 525; i++) line(i, "frame23");
        drain();
`ifdef VSYNC_FRAME_COUNT_EN
        fc_req = 16'd3;
`else
        fc_req = 16'd0;
`endif
        check("frame3_count", 32'(frame_count), 32'(fc_req));
        check("frame3_vsync_idle", 32'(vsync), 32'd1);

        // Skip: v_count 100 while expecting 99, then resync and track.
        for (int i = 0; i < 99; i++) line(i, "pre_skip");
        line(100, "skip_100");
        for (int i = 101; i < 111; i++) line(i, "post_skip");
        drain();
        check("skip_err_sticky", 32'(sync_err), 32'd1);

        // Out-of-range line forces a wrap.
        line(600, "oor_600");
        idle("oor_after");
        for (int i = 0; i < 491; i++) line(i, "to_sync");
        repeat (3) idle("in_sync");
        repeat (3) @(posedge clk);
        check("in_sync_vsync", 32'(vsync), 32'd0);

        // Asynchronous reset in SYNC.
        #3 rst = 1'b1;
        #1;
        check("async_rst_vsync", 32'(vsync), 32'd1);
        check("async_rst_vblank", 32'(v_blank), 32'd0);
        check("async_rst_fc_err", 32'({frame_count, sync_err}), 32'd0);
        model_reset();
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 6; i++) line(i, "post_rst_lines");
        drain();
        check("post_rst_no_err", 32'(sync_err), 32'd0);

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
